reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_if.sv | 13 +
 rtl/reset_sequencer.sv | 96 +++++++++
 tb/tb_reset_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: software reset, channel acks and sequencer status bundled as one port
interface reset_sequencer_if #(
  parameter int NUM_CH = 4
);
  logic              sw_rst_i;
  logic [NUM_CH-1:0] ch_ack_i;
  logic [NUM_CH-1:0] rst_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  modport master (input sw_rst_i, ch_ack_i, output rst_o, busy_o, done_o, err_o);
  modport slave  (output sw_rst_i, ch_ack_i, input rst_o, busy_o, done_o, err_o);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: stretches master reset, then releases channels in order, waiting for each ack
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int STRETCH     = 16,
  parameter int GAP         = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter bit OUT_POL     = 1'b1
) (
  input logic               clk,
  input logic               rst_i,
  reset_sequencer_if.master bus
);
  localparam int M1 = STRETCH > GAP ? STRETCH : GAP;
  localparam int MX = M1 > ACK_TIMEOUT ? M1 : ACK_TIMEOUT;
  localparam int CW = $clog2(MX + 1);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {ST_HOLD, ST_WAIT_ACK, ST_GAP, ST_DONE} state_t;
  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [NUM_CH-1:0] rst_q, rst_n;
  logic              done_q, done_n, busy_q, err_q, err_n;
  assign bus.rst_o  = rst_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
  assign bus.err_o  = err_q;
  // Outputs are computed as next-state values so every output comes straight from a flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    rst_n   = rst_q;
    done_n  = done_q;
    err_n   = err_q;
    if (bus.sw_rst_i) begin
      state_n = ST_HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      rst_n   = {NUM_CH{OUT_POL}};
      done_n  = 1'b0;
    end else begin
      case (state)
        ST_HOLD:
          if (cnt == CW'(STRETCH - 1)) begin
            state_n  = ST_WAIT_ACK;
            cnt_n    = '0;
            rst_n[0] = ~OUT_POL;
          end else cnt_n = cnt + 1'b1;
        ST_WAIT_ACK:
          if (bus.ch_ack_i[idx]) begin
            cnt_n = '0;
            if (idx == IW'(NUM_CH - 1)) begin
              state_n = ST_DONE;
              done_n  = 1'b1;
            end else if (GAP == 0) begin
              idx_n        = idx + 1'b1;
              rst_n[idx_n] = ~OUT_POL;
            end else state_n = ST_GAP;
          end else if (ACK_TIMEOUT > 0 && cnt == CW'(ACK_TIMEOUT - 1)) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
            rst_n   = {NUM_CH{OUT_POL}};
            err_n   = 1'b1;
          end else cnt_n = cnt + 1'b1;
        ST_GAP:
          if (cnt == CW'(GAP - 1)) begin
            state_n      = ST_WAIT_ACK;
            cnt_n        = '0;
            idx_n        = idx + 1'b1;
            rst_n[idx_n] = ~OUT_POL;
          end else cnt_n = cnt + 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= {NUM_CH{OUT_POL}};
      done_q <= 1'b0;
      busy_q <= 1'b1;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      rst_q  <= rst_n;
      done_q <= done_n;
      busy_q <= ~done_n;
      err_q  <= err_n;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: three configurations driven with random acks/resets against a release-count model
module tb_reset_sequencer;
  localparam int NCH [3] = '{4, 1, 3};
  localparam int STR [3] = '{16, 16, 3};
  localparam int GP  [3] = '{4, 0, 0};
  localparam int TO  [3] = '{64, 64, 5};
  localparam bit POL [3] = '{1'b1, 1'b0, 1'b1};
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw  = 1'b0;
  logic [3:0] ack = 4'hf;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         nr [3];
  int         ag [3];
  bit         gp [3];
  bit         dn [3];
  bit         er [3];
  reset_sequencer_if #(.NUM_CH(4)) b0 ();
  reset_sequencer_if #(.NUM_CH(1)) b1 ();
  reset_sequencer_if #(.NUM_CH(3)) b2 ();
  assign b0.sw_rst_i = sw;
  assign b1.sw_rst_i = sw;
  assign b2.sw_rst_i = sw;
  assign b0.ch_ack_i = ack;
  assign b1.ch_ack_i = ack[0:0];
  assign b2.ch_ack_i = ack[2:0];
  reset_sequencer #(.NUM_CH(4), .STRETCH(16), .GAP(4), .ACK_TIMEOUT(64), .OUT_POL(1'b1))
    d0 (.clk(clk), .rst_i(rst), .bus(b0));
  reset_sequencer #(.NUM_CH(1), .STRETCH(16), .GAP(0), .ACK_TIMEOUT(64), .OUT_POL(1'b0))
    d1 (.clk(clk), .rst_i(rst), .bus(b1));
  reset_sequencer #(.NUM_CH(3), .STRETCH(3), .GAP(0), .ACK_TIMEOUT(5), .OUT_POL(1'b1))
    d2 (.clk(clk), .rst_i(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  // nr = number of channels released so far; a channel is waited on once released and not yet acked
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        nr[i] = 0; ag[i] = 0; gp[i] = 0; dn[i] = 0; er[i] = 0;
      end else if (sw) begin
        nr[i] = 0; ag[i] = 0; gp[i] = 0; dn[i] = 0;
      end else if (dn[i]) begin
      end else if (nr[i] == 0) begin
        ag[i]++;
        if (ag[i] == STR[i]) begin nr[i] = 1; ag[i] = 0; end
      end else if (gp[i]) begin
        ag[i]++;
        if (ag[i] == GP[i]) begin nr[i]++; gp[i] = 0; ag[i] = 0; end
      end else if (ack[nr[i]-1]) begin
        ag[i] = 0;
        if (nr[i] == NCH[i]) dn[i] = 1;
        else if (GP[i] == 0) nr[i]++;
        else gp[i] = 1;
      end else begin
        ag[i]++;
        if (TO[i] > 0 && ag[i] == TO[i]) begin er[i] = 1; nr[i] = 0; ag[i] = 0; end
      end
    end
  endtask
  function automatic logic [31:0] expv(input int i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < NCH[i]; k++) r[k] = (k < nr[i]) ? ~POL[i] : POL[i];
    return {25'b0, r, ~dn[i], dn[i], er[i]};
  endfunction
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("d0", {25'b0, b0.rst_o, b0.busy_o, b0.done_o, b0.err_o}, expv(0));
    check("d1", {28'b0, b1.rst_o, b1.busy_o, b1.done_o, b1.err_o}, expv(1));
    check("d2", {26'b0, b2.rst_o, b2.busy_o, b2.done_o, b2.err_o}, expv(2));
  endtask
  task automatic do_reset();
    rst = 1'b1;
    sw  = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
  endtask
  initial begin
    int f [4];
    int dd, f1, d1d, ee;
    do_reset();
    ack = 4'hf;
    f = '{0, 0, 0, 0}; dd = 0; f1 = 0; d1d = 0;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      for (int k = 0; k < 4; k++) if (!b0.rst_o[k] && f[k] == 0) f[k] = e;
      if (b0.done_o && dd == 0) dd = e;
      if (b1.rst_o[0] && f1 == 0) f1 = e;
      if (b1.done_o && d1d == 0) d1d = e;
    end
    check("rel0_edge", f[0], 16);
    check("rel1_edge", f[1], 21);
    check("rel2_edge", f[2], 26);
    check("rel3_edge", f[3], 31);
    check("done_edge", dd, 32);
    check("pol0_rel_edge", f1, 16);
    check("pol0_done_edge", d1d, 17);
    sw = 1'b1;
    cyc();
    sw = 1'b0;
    check("sw_in_done", {b0.rst_o, b0.busy_o, b0.done_o}, 6'b111110);
    do_reset();
    ack = 4'b1011;
    f[2] = 0; ee = 0;
    for (int e = 1; e <= 300 && ee == 0; e++) begin
      cyc();
      if (!b0.rst_o[2] && f[2] == 0) f[2] = e;
      if (b0.err_o) ee = e;
    end
    check("timeout_delay", ee - f[2], 64);
    check("timeout_reassert", b0.rst_o, 4'hf);
    ack = 4'hf;
    repeat (20) cyc();
    sw = 1'b1;
    cyc();
    sw = 1'b0;
    check("err_sticky_sw", b0.err_o, 1'b1);
    repeat (10) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_clears_err", {b0.rst_o, b0.err_o}, 5'b11110);
    ack = 4'h0;
    repeat (79) cyc();
    sw = 1'b1;
    cyc();
    sw = 1'b0;
    check("sw_beats_timeout", {b0.rst_o, b0.busy_o, b0.err_o}, 6'b111110);
    for (int s = 0; s < 15; s++) begin
      int mode;
      logic [3:0] mask;
      mode = $urandom_range(0, 2);
      mask = 4'hf & ~(4'b1 << $urandom_range(0, 3));
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 399) == 0);
        sw  = ($urandom_range(0, 149) == 0);
        ack = mode == 0 ? 4'hf : mode == 1 ? (4'($urandom) & 4'($urandom)) : mask;
        cyc();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
